// File: rtl/img_dilation_lb.sv
// Streaming 3x3 binary dilation with internal two-line buffering and border masking.
// Pixel data and syncs pass through a fixed 3-clk delay aligned with post_imgbit.
module img_dilation_lb #(
  parameter int IMG_H = 800,
  parameter int IMG_V = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_vs,
  input  logic        pre_hs,
  input  logic        pre_clken,
  input  logic        pre_imgbit,
  input  logic [15:0] pre_img_data,
  output logic        post_vs,
  output logic        post_hs,
  output logic        post_clken,
  output logic        post_imgbit,
  output logic [15:0] post_img_data
);

  localparam int CW = 11;
  localparam int AW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] H_LIM = CW'(IMG_H);
  localparam logic [CW-1:0] V_LIM = CW'(IMG_V);

  logic [2:0]    vs_dly, hs_dly, clken_dly;
  logic [15:0]   data_dly [3];
  logic [CW-1:0] x_cnt, y_cnt;
  logic          accept, hs_fall, vs_rise, in_range;
  logic [AW-1:0] addr;

  assign accept   = pre_clken & pre_hs;
  assign hs_fall  = hs_dly[0] & ~pre_hs;
  assign vs_rise  = pre_vs & ~vs_dly[0];
  assign in_range = (x_cnt < H_LIM) && (y_cnt < V_LIM);
  assign addr     = x_cnt[AW-1:0];

  // Sync/data delay lines shift every clock regardless of pixel strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly    <= '0;
      hs_dly    <= '0;
      clken_dly <= '0;
      for (int i = 0; i < 3; i++) data_dly[i] <= '0;
    end else begin
      vs_dly      <= {vs_dly[1:0], pre_vs};
      hs_dly      <= {hs_dly[1:0], pre_hs};
      clken_dly   <= {clken_dly[1:0], pre_clken};
      data_dly[0] <= pre_img_data;
      data_dly[1] <= data_dly[0];
      data_dly[2] <= data_dly[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (hs_fall)
        x_cnt <= '0;
      else if (accept && x_cnt != '1)
        x_cnt <= x_cnt + 1'b1;
      if (vs_rise)
        y_cnt <= '0;
      else if (hs_fall && y_cnt < V_LIM)
        y_cnt <= y_cnt + 1'b1;
    end
  end

  // Stage 1: line-buffer read plus per-pixel side information.
  logic          acc_d1, first_d1, m1_d1, m2_d1, bit_d1, ok_d1;
  logic [AW-1:0] addr_d1;
  logic          rd1_reg, rd2_reg;
  logic          lb1 [IMG_H];
  logic          lb2 [IMG_H];

  // LB2 takes the old LB1 word one clock later, using the registered read.
  always_ff @(posedge clk) begin
    if (accept && in_range) lb1[addr] <= pre_imgbit;
    if (acc_d1 && ok_d1)    lb2[addr_d1] <= rd1_reg;
    rd1_reg <= lb1[addr];
    rd2_reg <= lb2[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_d1   <= 1'b0;
      first_d1 <= 1'b0;
      m1_d1    <= 1'b0;
      m2_d1    <= 1'b0;
      bit_d1   <= 1'b0;
      ok_d1    <= 1'b0;
      addr_d1  <= '0;
    end else begin
      acc_d1   <= accept;
      first_d1 <= (x_cnt == '0);
      m1_d1    <= (y_cnt != '0);
      m2_d1    <= (y_cnt > CW'(1));
      bit_d1   <= pre_imgbit;
      ok_d1    <= in_range;
      addr_d1  <= addr;
    end
  end

  // Stage 2: 3x3 window as three columns {row y-2, row y-1, row y}.
  logic [2:0] col_reg [3];
  logic       ok_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) col_reg[i] <= '0;
      ok_d2 <= 1'b0;
    end else if (acc_d1) begin
      col_reg[0] <= {rd2_reg & m2_d1, rd1_reg & m1_d1, bit_d1};
      col_reg[1] <= first_d1 ? 3'b000 : col_reg[0];
      col_reg[2] <= first_d1 ? 3'b000 : col_reg[1];
      ok_d2      <= ok_d1;
    end
  end

  // Stage 3: OR reduction, aligned with the third delay-line tap.
  logic result_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      result_reg <= 1'b0;
    else
      result_reg <= ok_d2 & ((|col_reg[0]) | (|col_reg[1]) | (|col_reg[2]));
  end

  assign post_vs       = vs_dly[2];
  assign post_hs       = hs_dly[2];
  assign post_clken    = clken_dly[2];
  assign post_img_data = data_dly[2];
  assign post_imgbit   = result_reg & hs_dly[2];

endmodule
